// File: rtl/fsm1_obs_monitor.sv
// fsm1 observation monitor: decodes the sampled fsm1 state, counts transitions
// and output1 strobes, logs event cycles into a trace FIFO drained over
// valid/ready, and flags overflow and prolonged inactivity.
// Optional build macro FSM1_OBS_TSTAMP_EN appends a wrapping cycle timestamp
// (cycles since reset release) to every trace record.
module fsm1_obs_monitor #(
    parameter int unsigned WARMUP      = 20,
    parameter int unsigned IDLE_LIMIT  = 16,
    parameter int unsigned TRACE_DEPTH = 8,
    parameter int unsigned CNT_W       = 16,
`ifdef FSM1_OBS_TSTAMP_EN
    localparam int unsigned TW         = 3 + CNT_W
`else
    localparam int unsigned TW         = 3
`endif
) (
    input  logic             GCLK_Pad,
    input  logic             reset_Pad,
    input  logic             state_obs0_Pad,
    input  logic             state_obs1_Pad,
    input  logic             output1_Pad,
    input  logic             clear,
    output logic [1:0]       cur_state,
    output logic [CNT_W-1:0] trans_count,
    output logic [CNT_W-1:0] out1_count,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [TW-1:0]    trace_data,
    output logic             overflow,
    output logic             idle_timeout
);

    localparam int unsigned WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int unsigned QW = $clog2(IDLE_LIMIT + 1);
    localparam int unsigned IW = $clog2(TRACE_DEPTH);
    localparam int unsigned OW = $clog2(TRACE_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] ST_WARM  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_QUIET = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic [QW-1:0]    quiet_q, quiet_d;
    logic [1:0]       cur_q, cur_d;
    logic [CNT_W-1:0] trans_q, trans_d;
    logic [CNT_W-1:0] out1_q, out1_d;
    logic             ovf_q, ovf_d;
    logic             idle_q, idle_d;
    logic             valid_q, valid_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [TW-1:0]    mem_q [TRACE_DEPTH];
    logic [TW-1:0]    mem_d [TRACE_DEPTH];
`ifdef FSM1_OBS_TSTAMP_EN
    logic [CNT_W-1:0] cyc_q, cyc_d;
`endif

    logic [1:0]    samp;
    logic          trans_hit;
    logic          evt;
    logic          pop;
    logic          push;
    logic          full;
    logic [TW-1:0] rec;

    assign cur_state    = cur_q;
    assign trans_count  = trans_q;
    assign out1_count   = out1_q;
    assign trace_valid  = valid_q;
    assign trace_data   = mem_q[0];
    assign overflow     = ovf_q;
    assign idle_timeout = idle_q;

    // State register: synchronous reset restarts warm-up with everything empty
    always_ff @(posedge GCLK_Pad) begin
        if (reset_Pad) begin
            state_q <= ST_WARM;
            warm_q  <= '0;
            quiet_q <= '0;
            cur_q   <= '0;
            trans_q <= '0;
            out1_q  <= '0;
            ovf_q   <= 1'b0;
            idle_q  <= 1'b0;
            valid_q <= 1'b0;
            occ_q   <= '0;
            for (int unsigned i = 0; i < TRACE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef FSM1_OBS_TSTAMP_EN
            cyc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            quiet_q <= quiet_d;
            cur_q   <= cur_d;
            trans_q <= trans_d;
            out1_q  <= out1_d;
            ovf_q   <= ovf_d;
            idle_q  <= idle_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
            mem_q   <= mem_d;
`ifdef FSM1_OBS_TSTAMP_EN
            cyc_q   <= cyc_d;
`endif
        end
    end

    // Next state: FSM sequencing, counters and shift-register trace FIFO (head at entry 0)
    always_comb begin
        state_d   = state_q;
        warm_d    = warm_q;
        quiet_d   = quiet_q;
        cur_d     = cur_q;
        trans_d   = trans_q;
        out1_d    = out1_q;
        ovf_d     = ovf_q;
        occ_d     = occ_q;
        mem_d     = mem_q;
        push      = 1'b0;
        samp      = {state_obs1_Pad, state_obs0_Pad};
        trans_hit = (samp != cur_q);
        evt       = trans_hit | output1_Pad;
        pop       = valid_q & trace_ready;
        full      = (occ_q == OW'(TRACE_DEPTH));
`ifdef FSM1_OBS_TSTAMP_EN
        cyc_d     = cyc_q + CNT_W'(1);
        rec       = {samp, output1_Pad, cyc_q};
`else
        rec       = {samp, output1_Pad};
`endif

        case (state_q)
            ST_WARM: begin
                if (warm_q == WW'(WARMUP - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    warm_d = warm_q + WW'(1);
                end
            end
            ST_RUN: begin
                if (evt) begin
                    quiet_d = '0;
                end else begin
                    quiet_d = quiet_q + QW'(1);
                    if (quiet_d == QW'(IDLE_LIMIT)) begin
                        state_d = ST_QUIET;
                    end
                end
            end
            ST_QUIET: begin
                if (evt) begin
                    state_d = ST_RUN;
                    quiet_d = '0;
                end
            end
            default: state_d = ST_WARM;
        endcase

        // Sampling is live in RUN and QUIET; clear suppresses the cycle's counting and logging
        if (state_q != ST_WARM) begin
            cur_d = samp;
            if (!clear) begin
                if (trans_hit && (trans_q != CNT_MAX)) begin
                    trans_d = trans_q + CNT_W'(1);
                end
                if (output1_Pad && (out1_q != CNT_MAX)) begin
                    out1_d = out1_q + CNT_W'(1);
                end
                if (evt) begin
                    if (!full || pop) begin
                        push = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end

        // Pop shifts the queue down; push lands just past the surviving entries
        if (pop) begin
            for (int unsigned i = 0; i + 1 < TRACE_DEPTH; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            occ_d = occ_q - OW'(1);
        end
        if (push) begin
            mem_d[IW'(occ_d)] = rec;
            occ_d = occ_d + OW'(1);
        end

        if (clear) begin
            occ_d   = '0;
            trans_d = '0;
            out1_d  = '0;
            ovf_d   = 1'b0;
        end

        valid_d = (occ_d != '0);
        idle_d  = (state_d == ST_QUIET);
    end

endmodule

// File: tb/tb_fsm1_obs_monitor.sv
// Self-checking bench for fsm1_obs_monitor: directed scenarios plus random
// traffic, checked against a cycle-count based reference model and a trace queue.
module tb_fsm1_obs_monitor;

    localparam int unsigned WARMUP     = 20;
    localparam int unsigned IDLE_LIMIT = 16;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned CNT_W      = 6;
    localparam int          CMAX       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, s0, s1, o1, clr, rdy;
    logic [1:0]       cur_state;
    logic [CNT_W-1:0] trans_count, out1_count;
    logic             trace_valid, overflow, idle_timeout;
    logic [2:0]       trace_data;

    always #5 clk = ~clk;

    fsm1_obs_monitor #(
        .WARMUP(WARMUP), .IDLE_LIMIT(IDLE_LIMIT), .TRACE_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .GCLK_Pad(clk), .reset_Pad(rst),
        .state_obs0_Pad(s0), .state_obs1_Pad(s1), .output1_Pad(o1),
        .clear(clr),
        .cur_state(cur_state), .trans_count(trans_count), .out1_count(out1_count),
        .trace_valid(trace_valid), .trace_ready(rdy), .trace_data(trace_data),
        .overflow(overflow), .idle_timeout(idle_timeout)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model state: phase derived from edges since reset release
    int         m_since, m_trans, m_out1, m_qrun;
    logic [1:0] m_cur;
    bit         m_ovf, m_idle, started;
    logic [2:0] exp_q [$];

    initial begin
        started = 1'b0;
        forever begin
            logic [1:0] s;
            bit tr, ev;
            @(posedge clk);
            if (rst) begin
                m_since = 0; m_trans = 0; m_out1 = 0; m_qrun = 0;
                m_cur = 2'b00; m_ovf = 1'b0; m_idle = 1'b0;
                exp_q.delete();
                started = 1'b1;
            end else begin
                m_since++;
                if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
                if (clr) begin
                    m_trans = 0; m_out1 = 0; m_ovf = 1'b0;
                    exp_q.delete();
                end
                if (m_since > int'(WARMUP)) begin
                    s  = {s1, s0};
                    tr = (s != m_cur);
                    ev = tr || o1;
                    if (!clr) begin
                        if (tr) m_trans = (m_trans + 1 > CMAX) ? CMAX : m_trans + 1;
                        if (o1) m_out1  = (m_out1 + 1 > CMAX) ? CMAX : m_out1 + 1;
                        if (ev) begin
                            if (exp_q.size() < DEPTH) exp_q.push_back({s, o1});
                            else m_ovf = 1'b1;
                        end
                    end
                    m_cur = s;
                    if (ev) begin
                        m_qrun = 0; m_idle = 1'b0;
                    end else begin
                        m_qrun++;
                        if (m_qrun >= int'(IDLE_LIMIT)) m_idle = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compares status every cycle and each accepted record against the queue head
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("cur_state", int'(cur_state), int'(m_cur));
                chk("trans_count", int'(trans_count), m_trans);
                chk("out1_count", int'(out1_count), m_out1);
                chk("overflow", int'(overflow), int'(m_ovf));
                chk("idle_timeout", int'(idle_timeout), int'(m_idle));
                chk("trace_valid", int'(trace_valid), int'(exp_q.size() != 0));
                if (trace_valid && rdy && exp_q.size() != 0)
                    chk("trace_data", int'(trace_data), int'(exp_q[0]));
            end
        end
    end

    task automatic cyc(input logic [1:0] s, input bit o, input bit c, input bit r);
        {s1, s0} = s; o1 = o; clr = c; rdy = r;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0] sd;
        int dens, rdyd;
        rst = 1'b1; s0 = 1'b0; s1 = 1'b0; o1 = 1'b0; clr = 1'b0; rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", int'(trace_valid), 0);
        chk("rst_trans", int'(trans_count), 0);

        // Warm-up ignores inputs; first RUN sample at edge 21
        repeat (WARMUP) cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk("warm_valid", int'(trace_valid), 0);
        chk("warm_trans", int'(trans_count), 0);
        cyc(2'b01, 1'b0, 1'b0, 1'b0);
        chk("t1_trans", int'(trans_count), 1);
        chk("t1_cur", int'(cur_state), 1);
        chk("t1_valid", int'(trace_valid), 1);
        chk("t1_data", int'(trace_data), 2);

        // Steady state 10 with three output1 strobes
        cyc(2'b10, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(2'b10, 1'b1, 1'b0, 1'b0);
        chk("t2_out1", int'(out1_count), 3);
        chk("t2_trans", int'(trans_count), 2);
        repeat (6) cyc(2'b10, 1'b0, 1'b0, 1'b1);
        chk("t2_drained", int'(trace_valid), 0);

        // Overflow on nine events into an eight-deep FIFO, then clear
        repeat (9) cyc(2'b10, 1'b1, 1'b0, 1'b0);
        chk("t3_ovf", int'(overflow), 1);
        cyc(2'b10, 1'b0, 1'b1, 1'b0);
        chk("t3_clr_ovf", int'(overflow), 0);
        chk("t3_clr_valid", int'(trace_valid), 0);

        // Full FIFO with simultaneous pop and push keeps eight entries
        repeat (8) cyc(2'b10, 1'b1, 1'b0, 1'b0);
        chk("t4_full_ovf", int'(overflow), 0);
        cyc(2'b10, 1'b1, 1'b0, 1'b1);
        chk("t4_poppush_ovf", int'(overflow), 0);
        cyc(2'b10, 1'b1, 1'b0, 1'b0);
        chk("t4_still_full", int'(overflow), 1);
        repeat (10) cyc(2'b10, 1'b0, 1'b0, 1'b1);

        // Idle timeout after sixteen event-free RUN cycles
        cyc(2'b11, 1'b0, 1'b0, 1'b1);
        repeat (IDLE_LIMIT - 1) cyc(2'b11, 1'b0, 1'b0, 1'b1);
        chk("t5_idle_early", int'(idle_timeout), 0);
        cyc(2'b11, 1'b0, 1'b0, 1'b1);
        chk("t5_idle", int'(idle_timeout), 1);
        cyc(2'b11, 1'b1, 1'b0, 1'b0);
        chk("t5_wake", int'(idle_timeout), 0);
        chk("t5_valid", int'(trace_valid), 1);
        chk("t5_data", int'(trace_data), 7);
        repeat (2) cyc(2'b11, 1'b0, 1'b0, 1'b1);

        // Mid-stream reset abandons queued records and repeats warm-up
        repeat (5) cyc(2'b01, 1'b1, 1'b0, 1'b0);
        chk("t6_queued", int'(trace_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("t6_valid", int'(trace_valid), 0);
        chk("t6_trans", int'(trans_count), 0);
        chk("t6_out1", int'(out1_count), 0);
        repeat (WARMUP) cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk("t6_warm_valid", int'(trace_valid), 0);
        cyc(2'b10, 1'b0, 1'b0, 1'b0);
        chk("t6_trans_again", int'(trans_count), 1);

        // Counter saturation
        for (int i = 0; i < 70; i++) cyc((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, 1'b1);
        chk("sat_trans", int'(trans_count), CMAX);
        chk("sat_out1", int'(out1_count), CMAX);

        // Random traffic in blocks of varying event density and drain rate
        sd = 2'b10;
        for (int blk = 0; blk < 20; blk++) begin
            dens = $urandom_range(0, 3);
            rdyd = $urandom_range(0, 4);
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 7) < dens) sd = 2'($urandom_range(0, 3));
                cyc(sd, $urandom_range(0, 7) < dens, (blk % 5 == 4) && ($urandom_range(0, 19) == 0),
                    $urandom_range(0, 3) < rdyd);
            end
        end
        repeat (12) cyc(sd, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
